// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encodings and counter-width helper shared by the serial adder slice
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// fulladder: single-bit full adder cell
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder reusing one full adder per clock
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum, fa_cout;
    logic             accept, last;

    fulladder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .c_in (carry),
        .sum  (fa_sum),
        .c_out(fa_cout)
    );

    // the unused 2'b11 encoding falls through to IDLE
    always_comb begin
        accept  = start && (state == ST_IDLE || state == ST_DONE);
        last    = (state == ST_SHIFT) && (cnt == LAST);
        state_n = accept ? ST_SHIFT :
                  (state == ST_SHIFT) ? (last ? ST_DONE : ST_SHIFT) : ST_IDLE;
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= c_in;
                cnt   <= '0;
                s_sh  <= '0;
            end else if (state == ST_SHIFT) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                s_sh  <= {fa_sum, s_sh[WIDTH-1:1]};
                carry <= fa_cout;
                cnt   <= cnt + CW'(1);
            end
            if (last) begin
                sum   <= {fa_sum, s_sh[WIDTH-1:1]};
                c_out <= fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench, directed WIDTH=8 cases plus random runs at WIDTH=2 and 32
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   fin = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic       rst8 = 1'b1, start8 = 1'b0, c8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       busy8, done8, cout8;
    logic [8:0] q8[$];
    int         k, bc, nd, bad;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .c_in(c8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
    );

    always @(negedge clk) begin
        if (!rst8 && done8) begin
            chk("w8_busy_done_excl", 64'(busy8), 64'd0);
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL w8_unexpected_done: got %0h expected no result", {cout8, sum8});
            end else begin
                chk("w8_sum", 64'({cout8, sum8}), 64'(q8.pop_front()));
            end
        end
    end

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int n, bz;
        a8 = x; b8 = y; c8 = c; start8 = 1'b1;
        q8.push_back(9'(x) + 9'(y) + 9'(c));
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        n = 0; bz = 0;
        while (!done8 && n < 20) begin
            bz += int'(busy8);
            n++;
            @(negedge clk);
        end
        chk("latency", 64'(n), 64'd8);
        chk("busy_cycles", 64'(bz), 64'd8);
        @(negedge clk);
        chk("done_pulse_width", 64'(done8), 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst8 = 1'b0;
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_done", 64'(done8), 64'd0);
        chk("rst_sum", 64'({cout8, sum8}), 64'd0);
        op8(8'h35, 8'h4A, 1'b0);
        op8(8'hFF, 8'h01, 1'b0);
        op8(8'hFF, 8'h00, 1'b1);
        // start pulsed mid-operation must be ignored
        a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h030);
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        nd = 0;
        repeat (10) begin
            nd += int'(done8);
            @(negedge clk);
        end
        chk("single_done", 64'(nd), 64'd1);
        // back-to-back with start held high
        a8 = 8'h80; b8 = 8'h80; c8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h100);
        @(posedge clk);
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h02;
        q8.push_back(9'h003);
        k = 0;
        while (!done8 && k < 20) begin
            k++;
            @(negedge clk);
        end
        chk("b2b_first_latency", 64'(k), 64'd8);
        @(negedge clk);
        start8 = 1'b0;
        k = 0; bad = 0;
        while (!done8 && k < 20) begin
            if (sum8 !== 8'h00 || cout8 !== 1'b1) bad++;
            k++;
            @(negedge clk);
        end
        chk("b2b_gap", 64'(k + 1), 64'd9);
        chk("b2b_hold", 64'(bad), 64'd0);
        @(negedge clk);
        // reset during SHIFT cycle 4 aborts the operation
        a8 = 8'h0F; b8 = 8'h0F; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        chk("abort_busy", 64'(busy8), 64'd0);
        chk("abort_done", 64'(done8), 64'd0);
        chk("abort_sum", 64'({cout8, sum8}), 64'd0);
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            nd += int'(done8);
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        chk("w8_queue_empty", 64'(q8.size()), 64'd0);
        fin++;
    end

    for (genvar g = 0; g < 2; g++) begin : gr
        localparam int W = (g == 0) ? 2 : 32;
        logic         st = 1'b0, rc = 1'b0;
        logic [W-1:0] ra = '0, rb = '0, rs;
        logic         rbusy, rdone, rco;
        logic [W:0]   q[$];

        serial_adder #(.WIDTH(W)) u (
            .clk(clk), .rst(rst), .start(st), .a(ra), .b(rb), .c_in(rc),
            .busy(rbusy), .done(rdone), .sum(rs), .c_out(rco)
        );

        always @(negedge clk) begin
            if (!rst && rdone) begin
                chk($sformatf("w%0d_busy_done_excl", W), 64'(rbusy), 64'd0);
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL w%0d_unexpected_done: got %0h expected no result", W, {rco, rs});
                end else begin
                    chk($sformatf("w%0d_sum", W), 64'({rco, rs}), 64'(q.pop_front()));
                end
            end
        end

        initial begin
            int n;
            wait (!rst);
            @(negedge clk);
            repeat (1000) begin
                ra = W'($urandom);
                rb = W'($urandom);
                rc = 1'($urandom);
                st = 1'b1;
                q.push_back((W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc));
                @(posedge clk);
                @(negedge clk);
                st = 1'b0;
                n = 0;
                while (!rdone && n < W + 4) begin
                    n++;
                    @(negedge clk);
                end
                if (!rdone) begin
                    errors++;
                    $display("FAIL w%0d_timeout: got no done after %0d cycles expected done", W, n);
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            repeat (W + 4) @(negedge clk);
            chk($sformatf("w%0d_queue_empty", W), 64'(q.size()), 64'd0);
            fin++;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        fork
            wait (fin == 3);
            begin
                #900000;
                errors++;
                $display("FAIL global_timeout: got %0d finished drivers expected 3", fin);
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
